// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - CPU trace capture unit with cycle-tagged FWFT FIFO and auto-stop
//
// Records {cycle, pc, effective write flag, write address, write data} while
// capture runs, and streams the samples out through a valid/ready read port.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-low reset
//   start_i             level-sensitive run request; capture happens only while high
//   clear_i             synchronous flush of FIFO, counters and flags; returns to IDLE
//   mode_i              0 = record every captured cycle, 1 = record effective writes only
//   pc_i, rw_*_i        CPU architectural state sampled each captured cycle
//   rd_valid_o/ready_i  head-of-FIFO handshake; rd_*_o carry the head entry
//   count_o             FIFO occupancy
//   overflow_o          sticky: a sample was dropped because the FIFO was full
//   drop_cnt_o          saturating count of dropped samples
//   done_o              capture finished after STOP_CYCLES captured cycles

module cpu_trace_buffer #(
    parameter int PC_W        = 32,
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 16,
    parameter int STOP_CYCLES = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     clear_i,
    input  logic                     mode_i,
    input  logic [PC_W-1:0]          pc_i,
    input  logic                     rw_en_i,
    input  logic [REG_AW-1:0]        rw_addr_i,
    input  logic [DATA_W-1:0]        rw_data_i,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [CNT_W-1:0]         rd_cycle_o,
    output logic [PC_W-1:0]          rd_pc_o,
    output logic                     rd_wen_o,
    output logic [REG_AW-1:0]        rd_addr_o,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         drop_cnt_o,
    output logic                     done_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = CNT_W + PC_W + 1 + REG_AW + DATA_W;

    localparam logic                 AUTO_STOP = (STOP_CYCLES != 0);
    localparam logic [CNT_W-1:0]     STOP_LAST = CNT_W'((STOP_CYCLES == 0) ? 0 : STOP_CYCLES - 1);
    localparam logic [PTR_W:0]       FULL_CNT  = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [ENT_W-1:0]   head_q, head_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   drop_q, drop_d;

    // Sample storage has no reset: entries are only ever observed through head_q.
    logic [ENT_W-1:0]   mem_q [DEPTH];

    logic               capture;
    logic               wen_eff;
    logic [ENT_W-1:0]   sample;
    logic               push_req;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;
    logic [PTR_W:0]     remain;

    // ------------------------------------------------------------------
    // Sampling and FIFO handshake
    // ------------------------------------------------------------------
    always_comb begin
        capture  = (state_q == S_RUN) && start_i;
        wen_eff  = rw_en_i && (rw_addr_i != '0);
        sample   = {cycle_q, pc_i, wen_eff, rw_addr_i, rw_data_i};
        push_req = capture && (!mode_i || wen_eff);
        full     = (count_q == FULL_CNT);
        pop      = !clear_i && (count_q != '0) && rd_ready_i;
        // A pop frees the slot a same-cycle push needs when full.
        push     = !clear_i && push_req && (!full || pop);
        drop     = !clear_i && push_req && full && !pop;
        // Entries left in storage after this cycle's pop, before the push.
        remain   = count_q - {{PTR_W{1'b0}}, pop};
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (capture && AUTO_STOP && (cycle_q == STOP_LAST)) begin
                    state_d = S_DONE;
                end else if (!start_i) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (clear_i) begin
            state_d = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        cycle_d  = cycle_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;

        if (clear_i) begin
            cycle_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
            ovf_d    = 1'b0;
            drop_d   = '0;
        end else begin
            if (capture) begin
                cycle_d = cycle_q + CNT_W'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != '1) begin
                    drop_d = drop_q + CNT_W'(1);
                end
            end
            // The head register mirrors the oldest entry. When storage is
            // drained by this cycle's pop, the incoming sample becomes the
            // head directly; when nothing is left, the last head is held.
            if (remain != '0) begin
                head_d = mem_q[rd_ptr_d];
            end else if (push) begin
                head_d = sample;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            cycle_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            cycle_q  <= cycle_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_valid_o = (count_q != '0);
    assign count_o    = count_q;
    assign overflow_o = ovf_q;
    assign drop_cnt_o = drop_q;
    assign done_o     = (state_q == S_DONE);
    assign {rd_cycle_o, rd_pc_o, rd_wen_o, rd_addr_o, rd_data_o} = head_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb/tb_cpu_trace_buffer.sv - self-checking bench for cpu_trace_buffer

module tb_cpu_trace_buffer;

    localparam int DEPTH = 4;
    localparam int STOP  = 10;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        clear_i;
    logic        mode_i;
    logic [31:0] pc_i;
    logic        rw_en_i;
    logic [4:0]  rw_addr_i;
    logic [31:0] rw_data_i;
    logic        rd_valid_o;
    logic        rd_ready_i;
    logic [15:0] rd_cycle_o;
    logic [31:0] rd_pc_o;
    logic        rd_wen_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic [2:0]  count_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;
    logic        done_o;

    cpu_trace_buffer #(
        .PC_W(32), .DATA_W(32), .REG_AW(5), .DEPTH(DEPTH), .CNT_W(16), .STOP_CYCLES(STOP)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i), .mode_i(mode_i),
        .pc_i(pc_i), .rw_en_i(rw_en_i), .rw_addr_i(rw_addr_i), .rw_data_i(rw_data_i),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_cycle_o(rd_cycle_o),
        .rd_pc_o(rd_pc_o), .rd_wen_o(rd_wen_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
        .count_o(count_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [15:0] cyc;
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    // Reference model: a queue of recorded samples plus run/stop bookkeeping.
    ent_t        mq[$];
    ent_t        mhead;
    logic [15:0] mcyc;
    int          mphase;   // 0 stopped, 1 capturing, 2 finished
    bit          movf;
    int          mdrop;

    ent_t        dut_pops[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mhead  = '0;
        mcyc   = '0;
        mphase = 0;
        movf   = 1'b0;
        mdrop  = 0;
    endtask

    task automatic model_step();
        bit   mpop, cap, wen;
        ent_t s;
        if (clear_i) begin
            model_reset();
        end else begin
            mpop = (mq.size() > 0) && rd_ready_i;
            cap  = (mphase == 1) && start_i;
            wen  = rw_en_i && (rw_addr_i != 5'd0);
            s    = '{cyc: mcyc, pc: pc_i, wen: wen, addr: rw_addr_i, data: rw_data_i};
            if (mpop) void'(mq.pop_front());
            if (cap && (!mode_i || wen)) begin
                if (mq.size() < DEPTH) mq.push_back(s);
                else begin
                    movf = 1'b1;
                    if (mdrop < 65535) mdrop++;
                end
            end
            if (mq.size() > 0) mhead = mq[0];
            if (mphase == 0) begin
                if (start_i) mphase = 1;
            end else if (mphase == 1) begin
                if (cap && (int'(mcyc) == STOP - 1)) mphase = 2;
                else if (!start_i) mphase = 0;
            end
            if (cap) mcyc = mcyc + 16'd1;
        end
    endtask

    task automatic compare_all();
        check("rd_valid", 64'(rd_valid_o), 64'(mq.size() != 0));
        check("count",    64'(count_o),    64'(mq.size()));
        check("rd_cycle", 64'(rd_cycle_o), 64'(mhead.cyc));
        check("rd_pc",    64'(rd_pc_o),    64'(mhead.pc));
        check("rd_wen",   64'(rd_wen_o),   64'(mhead.wen));
        check("rd_addr",  64'(rd_addr_o),  64'(mhead.addr));
        check("rd_data",  64'(rd_data_o),  64'(mhead.data));
        check("overflow", 64'(overflow_o), 64'(movf));
        check("drop_cnt", 64'(drop_cnt_o), 64'(mdrop));
        check("done",     64'(done_o),     64'(mphase == 2));
    endtask

    task automatic step();
        if (rd_valid_o && rd_ready_i && !clear_i)
            dut_pops.push_back('{cyc: rd_cycle_o, pc: rd_pc_o, wen: rd_wen_o,
                                 addr: rd_addr_o, data: rd_data_o});
        @(posedge clk_i);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        start_i = 1'b0;
        step();
        clear_i = 1'b0;
        dut_pops.delete();
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; clear_i = 1'b0; mode_i = 1'b0; pc_i = '0;
        rw_en_i = 1'b0; rw_addr_i = '0; rw_data_i = '0; rd_ready_i = 1'b0;
        model_reset();
        #3;
        compare_all();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        // Record every cycle, drained continuously, auto-stop after 10.
        dut_pops.delete();
        start_i = 1'b1; mode_i = 1'b0; rd_ready_i = 1'b1;
        for (int k = 0; k < 14; k++) begin
            pc_i = {14'd0, mcyc, 2'b00};
            step();
        end
        check("t1_done", 64'(done_o), 64'd1);
        check("t1_ovf", 64'(overflow_o), 64'd0);
        check("t1_npop", 64'(dut_pops.size()), 64'd10);
        for (int i = 0; i < dut_pops.size() && i < 10; i++) begin
            check("t1_cyc", 64'(dut_pops[i].cyc), 64'(i));
            check("t1_pc", 64'(dut_pops[i].pc), 64'(4 * i));
        end

        // Write-only mode; the R0 write must not be recorded.
        do_clear();
        start_i = 1'b1; mode_i = 1'b1; rd_ready_i = 1'b1;
        for (int k = 0; k < 14; k++) begin
            rw_en_i = 1'b0; rw_addr_i = 5'($urandom); rw_data_i = $urandom;
            if (mphase == 1 && mcyc == 16'd2) begin rw_en_i = 1'b1; rw_addr_i = 5'd8; rw_data_i = 32'd5; end
            if (mphase == 1 && mcyc == 16'd3) begin rw_en_i = 1'b1; rw_addr_i = 5'd0; rw_data_i = 32'd7; end
            if (mphase == 1 && mcyc == 16'd6) begin rw_en_i = 1'b1; rw_addr_i = 5'd9; rw_data_i = 32'd3; end
            pc_i = $urandom;
            step();
        end
        rw_en_i = 1'b0;
        check("t2_npop", 64'(dut_pops.size()), 64'd2);
        if (dut_pops.size() == 2) begin
            check("t2_e0", {dut_pops[0].cyc, dut_pops[0].wen, dut_pops[0].addr, dut_pops[0].data},
                  {16'd2, 1'b1, 5'd8, 32'd5});
            check("t2_e1", {dut_pops[1].cyc, dut_pops[1].wen, dut_pops[1].addr, dut_pops[1].data},
                  {16'd6, 1'b1, 5'd9, 32'd3});
        end

        // Overflow with no reader, then full FIFO with push and pop together.
        do_clear();
        start_i = 1'b1; mode_i = 1'b0; rd_ready_i = 1'b0;
        for (int k = 0; k < 7; k++) begin pc_i = $urandom; step(); end
        check("t3_count", 64'(count_o), 64'd4);
        check("t3_ovf", 64'(overflow_o), 64'd1);
        check("t3_drop", 64'(drop_cnt_o), 64'd2);
        check("t3_head", 64'(rd_cycle_o), 64'd0);
        rd_ready_i = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            pc_i = $urandom;
            step();
            check("t4_count", 64'(count_o), 64'd4);
            check("t4_drop", 64'(drop_cnt_o), 64'd2);
            check("t4_head", 64'(rd_cycle_o), 64'(k));
        end
        for (int k = 0; k < 8; k++) begin pc_i = $urandom; step(); end

        // Pause mid-run: no pushes while paused, no gap in cycle index.
        do_clear();
        start_i = 1'b1; mode_i = 1'b0; rd_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin pc_i = $urandom; step(); end
        start_i = 1'b0;
        for (int k = 0; k < 3; k++) begin pc_i = $urandom; step(); end
        check("t5_pause_cnt", 64'(count_o), 64'd0);
        start_i = 1'b1;
        for (int k = 0; k < 10; k++) begin pc_i = $urandom; step(); end
        check("t5_npop", 64'(dut_pops.size()), 64'd10);
        for (int i = 0; i < dut_pops.size() && i < 10; i++)
            check("t5_cyc", 64'(dut_pops[i].cyc), 64'(i));

        // Asynchronous reset with entries queued.
        do_clear();
        start_i = 1'b1; rd_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin pc_i = $urandom; step(); end
        check("t6_pre_cnt", 64'(count_o), 64'd3);
        #2 rst_i = 1'b0;
        #1;
        model_reset();
        check("t6_valid", 64'(rd_valid_o), 64'd0);
        check("t6_count", 64'(count_o), 64'd0);
        check("t6_done", 64'(done_o), 64'd0);
        compare_all();
        #3 rst_i = 1'b1;
        start_i = 1'b0;

        // Finish with an overflowed FIFO, ignore start in DONE, then clear.
        start_i = 1'b1; rd_ready_i = 1'b0;
        for (int k = 0; k < 13; k++) begin pc_i = $urandom; step(); end
        check("t7_done", 64'(done_o), 64'd1);
        check("t7_drop", 64'(drop_cnt_o), 64'd6);
        check("t7_count", 64'(count_o), 64'd4);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check("t7_clr_done", 64'(done_o), 64'd0);
        check("t7_clr_ovf", 64'(overflow_o), 64'd0);
        check("t7_clr_drop", 64'(drop_cnt_o), 64'd0);
        check("t7_clr_count", 64'(count_o), 64'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            clear_i    = ($urandom_range(99) < 2) || (mphase == 2 && $urandom_range(9) == 0);
            start_i    = ($urandom_range(99) < 85);
            mode_i     = $urandom_range(1);
            rw_en_i    = $urandom_range(1);
            rw_addr_i  = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
            rw_data_i  = $urandom;
            pc_i       = $urandom;
            rd_ready_i = ($urandom_range(99) < 60);
            step();
        end
        clear_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Synthesizable hardware trace unit that sits beside the CPU and records the architectural state the CPU simulation bench prints each cycle: PC plus register-file writeback.
- Captures samples into a parametrised FIFO tagged with a cycle count, and stops automatically after a programmable number of cycles.
- Replaces per-cycle register dumps with a streamed trace that is drained by a valid/ready reader (debug port or bench).

Parameters:
PC_W, 32, PC width
DATA_W, 32, register data width
REG_AW, 5, register address width
DEPTH, 16, FIFO entries; power of two, at least 2
CNT_W, 16, width of cycle counter and drop counter
STOP_CYCLES, 10, captured cycles before auto-stop; 0 = never stop

Ports:
clk_i  in  1  clock, all state updates on the rising edge
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  level-sensitive; capture runs while high
clear_i  in  1  synchronous clear: flush FIFO, reset counters/flags, go to IDLE
mode_i  in  1  0 = record every cycle; 1 = record register writes only
pc_i  in  PC_W  current CPU PC
rw_en_i  in  1  register write enable
rw_addr_i  in  REG_AW  register write address
rw_data_i  in  DATA_W  register write data
rd_valid_o  out  1  FIFO head is valid
rd_ready_i  in  1  consumer accepts the head entry
rd_cycle_o  out  CNT_W  head entry: cycle index
rd_pc_o  out  PC_W  head entry: PC
rd_wen_o  out  1  head entry: effective write flag
rd_addr_o  out  REG_AW  head entry: write address
rd_data_o  out  DATA_W  head entry: write data
count_o  out  clog2(DEPTH)+1  current occupancy
overflow_o  out  1  sticky flag: at least one sample dropped
drop_cnt_o  out  CNT_W  dropped samples, saturating
done_o  out  1  high in the DONE state

Behaviour:
- Reset (rst_i=0, async): state IDLE; FIFO empty; cycle counter 0. All outputs 0: rd_valid_o, count_o, overflow_o, drop_cnt_o, done_o, and all rd_* fields.
- FSM states IDLE, RUN, DONE:
  - IDLE -> RUN when start_i=1.
  - RUN -> IDLE when start_i=0. This is a pause; the cycle counter is retained, and re-asserting start_i resumes.
  - RUN -> DONE on the edge where the cycle counter (before increment) equals STOP_CYCLES-1, and STOP_CYCLES != 0.
  - DONE is left only by clear_i or reset. start_i is ignored in DONE.
- clear_i has priority over all other activity in the same cycle, including push, pop and state transitions.
- Each RUN cycle:
  - A sample is formed as {cycle, pc_i, wen_eff, rw_addr_i, rw_data_i}.
  - wen_eff = rw_en_i AND (rw_addr_i != 0); writes to R0 are never effective.
  - After sampling, the cycle counter increments. With STOP_CYCLES=0 it wraps modulo 2^CNT_W.
- Push rule: mode_i=0 pushes every RUN cycle; mode_i=1 pushes only when wen_eff=1. No push occurs in IDLE or DONE.
- FIFO is first-word-fall-through with registered storage. A sample taken at edge k is visible on rd_* at the earliest after edge k (the next cycle). Latency is 1 cycle.
- rd_valid_o = (count_o != 0). A pop occurs when rd_valid_o & rd_ready_i. rd_* fields hold while rd_valid_o=1 and rd_ready_i=0.
- Empty FIFO: rd_ready_i has no effect; rd_* hold their last values.
- Full FIFO, push with no pop: the new sample is dropped. overflow_o is set (sticky) and drop_cnt_o increments, saturating at 2^CNT_W-1.
- Full FIFO, push and pop in the same cycle: both occur, occupancy stays DEPTH, no drop.
- Empty FIFO, push and pop in the same cycle: pop is not possible (rd_valid_o=0), so only the push occurs.
- Pointers are clog2(DEPTH) bits and wrap naturally.
- Draining continues in IDLE and DONE.
- Reset asserted mid-run or mid-drain discards all entries immediately.

Test Plan:
- Reset, start_i=1, mode_i=0, STOP_CYCLES=10, rd_ready_i=1, pc_i stepping 0,4,8,... -> exactly 10 entries with cycle 0..9 and pc 0..36; done_o rises the cycle after cycle 9 is captured; no overflow.
- mode_i=1 with writes R8<=5 at cycle 2, R0<=7 at cycle 3, R9<=3 at cycle 6 -> 2 entries, (2,R8,5) and (6,R9,3); the R0 write is not recorded.
- DEPTH=4, STOP_CYCLES=0, rd_ready_i=0 for 6 RUN cycles -> count_o=4, entries hold cycles 0..3, overflow_o=1, drop_cnt_o=2.
- Full FIFO with rd_ready_i=1 during a push -> count_o stays 4, no drop, head advances by one per cycle.
- start_i low for 3 cycles mid-run, then high -> no pushes during the pause; cycle index continues without a gap.
- Reset pulse mid-run with 3 entries queued -> rd_valid_o=0, count_o=0, done_o=0 immediately; clear_i in DONE -> IDLE with counters and flags zeroed.
